// File: rtl/ft600_pkg.sv
// Shared types and widths for the FT600 245-sync bus emulator.
package ft600_pkg;

    localparam int unsigned FT_DATA_W = 16;
    localparam int unsigned FT_BE_W   = 2;

    typedef struct packed {
        logic [FT_DATA_W-1:0] data;
        logic [FT_BE_W-1:0]   be;
    } ft600_word_t;

endpackage

// File: rtl/ft600_emu_fifo.sv
// First-word-fall-through synchronous FIFO of ft600_word_t.
// Push is ignored when full, pop is ignored when empty; count_next_o exposes the
// occupancy that will be registered at the next edge so callers can build
// registered flags without a cycle of lag.
module ft600_emu_fifo
    import ft600_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  ft600_word_t            wdata_i,
    input  logic                   pop_i,
    output ft600_word_t            rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic [$clog2(DEPTH):0] count_next_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

    ft600_word_t   mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == FullCnt);
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Occupancy next state; simultaneous push/pop leaves it unchanged
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointers and count; reset flushes the FIFO
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o      = mem_q[rptr_q];
    assign count_o      = count_q;
    assign count_next_o = count_d;

endmodule

// File: rtl/ft600_bus_emulator.sv
// FT600 chip-side emulator for the 245-sync FIFO bus, with a valid/ready host port.
// Optional: define FT600_EMU_TXE_GAP_EN to force ftdi_txe_n high for two cycles
// after every TX_BURST accepted words (FT600 packet boundary model).
module ft600_bus_emulator
    import ft600_pkg::*;
#(
    parameter int unsigned RX_DEPTH = 16,
    parameter int unsigned TX_DEPTH = 16,
    parameter int unsigned TX_BURST = 8
) (
    input  logic                      ftdi_clk,
    input  logic                      rst,
    output logic                      ftdi_rxf_n,
    output logic                      ftdi_txe_n,
    input  logic                      ftdi_oe_n,
    input  logic                      ftdi_rd_n,
    input  logic                      ftdi_wr_n,
    inout  wire  [FT_DATA_W-1:0]      ftdi_data,
    inout  wire  [FT_BE_W-1:0]        ftdi_be,
    input  logic                      host_rx_valid,
    input  logic [FT_DATA_W-1:0]      host_rx_data,
    input  logic [FT_BE_W-1:0]        host_rx_be,
    output logic                      host_rx_ready,
    output logic                      host_tx_valid,
    output logic [FT_DATA_W-1:0]      host_tx_data,
    output logic [FT_BE_W-1:0]        host_tx_be,
    input  logic                      host_tx_ready,
    output logic [$clog2(RX_DEPTH):0] rx_count,
    output logic [$clog2(TX_DEPTH):0] tx_count,
    output logic                      bus_err
);

    localparam int unsigned TCW = $clog2(TX_DEPTH) + 1;
    localparam logic [TCW-1:0] TxFullCnt = TCW'(TX_DEPTH);

    ft600_word_t rx_head, rx_wdata, tx_head, tx_wdata, drv_word;
    logic rx_push, rx_pop, rx_full, rx_empty;
    logic tx_push, tx_pop, tx_empty, unused_tx_full;
    logic [$clog2(RX_DEPTH):0] rx_cnt_next;
    logic [TCW-1:0]            tx_cnt_next;
    logic drive_en, be_nz, txe_gap;
    logic rxf_n_d, txe_n_d, bus_err_d, ready_en_q;

    assign rx_wdata = '{data: host_rx_data, be: host_rx_be};
    assign tx_wdata = '{data: ftdi_data, be: ftdi_be};
    assign be_nz    = (ftdi_be != '0);

    assign host_rx_ready = ready_en_q & ~rx_full;
    assign rx_push       = host_rx_valid & host_rx_ready;
    assign rx_pop        = ~ftdi_oe_n & ~ftdi_rd_n;
    // be=00 with wr_n low is the end-of-burst idle word, not data
    assign tx_push       = ~ftdi_wr_n & ~ftdi_txe_n & be_nz;
    assign tx_pop        = host_tx_ready;

    ft600_emu_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk_i        (ftdi_clk),
        .rst_i        (rst),
        .push_i       (rx_push),
        .wdata_i      (rx_wdata),
        .pop_i        (rx_pop),
        .rdata_o      (rx_head),
        .full_o       (rx_full),
        .empty_o      (rx_empty),
        .count_o      (rx_count),
        .count_next_o (rx_cnt_next)
    );

    ft600_emu_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_i        (ftdi_clk),
        .rst_i        (rst),
        .push_i       (tx_push),
        .wdata_i      (tx_wdata),
        .pop_i        (tx_pop),
        .rdata_o      (tx_head),
        .full_o       (unused_tx_full),
        .empty_o      (tx_empty),
        .count_o      (tx_count),
        .count_next_o (tx_cnt_next)
    );

    assign host_tx_valid = ~tx_empty;
    assign host_tx_data  = tx_head.data;
    assign host_tx_be    = tx_head.be;

    // Bus is released combinationally by rst and never driven while the master writes
    assign drive_en  = ~rst & ~ftdi_oe_n & ftdi_wr_n;
    assign drv_word  = rx_empty ? '0 : rx_head;
    assign ftdi_data = drive_en ? drv_word.data : {FT_DATA_W{1'bz}};
    assign ftdi_be   = drive_en ? drv_word.be : {FT_BE_W{1'bz}};

`ifdef FT600_EMU_TXE_GAP_EN
    localparam int unsigned BW = (TX_BURST > 1) ? $clog2(TX_BURST) : 1;
    logic [BW-1:0] burst_q, burst_d;
    logic [1:0]    gap_q, gap_d;

    // Count accepted words and open a two-cycle gap at each packet boundary
    always_comb begin
        burst_d = burst_q;
        gap_d   = (gap_q != 2'd0) ? gap_q - 2'd1 : 2'd0;
        if (tx_push) begin
            if (burst_q == BW'(TX_BURST - 1)) begin
                burst_d = '0;
                gap_d   = 2'd2;
            end else begin
                burst_d = burst_q + 1'b1;
            end
        end
    end

    // Packet counter and gap timer state
    always_ff @(posedge ftdi_clk or posedge rst) begin
        if (rst) begin
            burst_q <= '0;
            gap_q   <= 2'd0;
        end else begin
            burst_q <= burst_d;
            gap_q   <= gap_d;
        end
    end

    assign txe_gap = (gap_d != 2'd0);
`else
    logic unused_tx_burst;
    assign unused_tx_burst = ^TX_BURST;
    assign txe_gap         = 1'b0;
`endif

    // Flags track next-state occupancy; bus_err accumulates protocol violations
    always_comb begin
        rxf_n_d   = (rx_cnt_next == '0);
        txe_n_d   = (tx_cnt_next == TxFullCnt) | txe_gap;
        bus_err_d = bus_err
                  | (~ftdi_rd_n & rx_empty)
                  | (~ftdi_wr_n & be_nz & ftdi_txe_n)
                  | (~ftdi_oe_n & ~ftdi_wr_n);
    end

    // Registered flags and host-ready enable
    always_ff @(posedge ftdi_clk or posedge rst) begin
        if (rst) begin
            ftdi_rxf_n <= 1'b1;
            ftdi_txe_n <= 1'b1;
            bus_err    <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            ftdi_rxf_n <= rxf_n_d;
            ftdi_txe_n <= txe_n_d;
            bus_err    <= bus_err_d;
            ready_en_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ft600_bus_emulator.sv
// Directed self-checking bench for ft600_bus_emulator.
module tb_ft600_bus_emulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, oe_n, rd_n, wr_n;
    logic        tb_drv;
    logic [15:0] tb_data;
    logic [1:0]  tb_be;
    wire  [15:0] ftdi_data;
    wire  [1:0]  ftdi_be;
    logic        rxf_n, txe_n, bus_err;
    logic        rx_valid, rx_ready, tx_valid, tx_ready;
    logic [15:0] rx_data, tx_data;
    logic [1:0]  rx_be, tx_be;
    logic [4:0]  rx_count, tx_count;

    int n_cmp  = 0;
    int n_fail = 0;

    assign ftdi_data = tb_drv ? tb_data : 16'hzzzz;
    assign ftdi_be   = tb_drv ? tb_be : 2'bzz;

    ft600_bus_emulator #(.RX_DEPTH(16), .TX_DEPTH(16), .TX_BURST(4)) dut (
        .ftdi_clk      (clk),
        .rst           (rst),
        .ftdi_rxf_n    (rxf_n),
        .ftdi_txe_n    (txe_n),
        .ftdi_oe_n     (oe_n),
        .ftdi_rd_n     (rd_n),
        .ftdi_wr_n     (wr_n),
        .ftdi_data     (ftdi_data),
        .ftdi_be       (ftdi_be),
        .host_rx_valid (rx_valid),
        .host_rx_data  (rx_data),
        .host_rx_be    (rx_be),
        .host_rx_ready (rx_ready),
        .host_tx_valid (tx_valid),
        .host_tx_data  (tx_data),
        .host_tx_be    (tx_be),
        .host_tx_ready (tx_ready),
        .rx_count      (rx_count),
        .tx_count      (tx_count),
        .bus_err       (bus_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        oe_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; tb_drv = 1'b0; tb_data = '0; tb_be = '0;
        rx_valid = 1'b0; rx_data = '0; rx_be = '0; tx_ready = 1'b0;
    endtask

    task automatic do_reset;
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic host_push(input logic [15:0] d, input logic [1:0] b);
        rx_valid = 1'b1; rx_data = d; rx_be = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic test_reset;
        idle();
        rst = 1'b1;
        tick(); tick();
        n_cmp++; if (rxf_n !== 1'b1) begin n_fail++; $display("FAIL rst_rxf_n got %b want 1", rxf_n); end
        n_cmp++; if (txe_n !== 1'b1) begin n_fail++; $display("FAIL rst_txe_n got %b want 1", txe_n); end
        n_cmp++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL rst_bus_err got %b want 0", bus_err); end
        n_cmp++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL rst_rx_ready got %b want 0", rx_ready); end
        n_cmp++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tx_valid got %b want 0", tx_valid); end
        n_cmp++; if (rx_count !== 5'd0 || tx_count !== 5'd0) begin
            n_fail++; $display("FAIL rst_counts got %0d/%0d want 0/0", rx_count, tx_count);
        end
        rst = 1'b0;
        tick();
        n_cmp++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL rel_rx_ready got %b want 1", rx_ready); end
        n_cmp++; if (txe_n !== 1'b0) begin n_fail++; $display("FAIL rel_txe_n got %b want 0", txe_n); end
    endtask

    task automatic test_read;
        do_reset();
        host_push(16'h1234, 2'b11);
        n_cmp++; if (rxf_n !== 1'b0) begin n_fail++; $display("FAIL rd_rxf_fall got %b want 0", rxf_n); end
        host_push(16'hABCD, 2'b01);
        n_cmp++; if (rx_count !== 5'd2) begin n_fail++; $display("FAIL rd_cnt2 got %0d want 2", rx_count); end
        oe_n = 1'b0;
        #1;
        n_cmp++; if (ftdi_data !== 16'h1234 || ftdi_be !== 2'b11) begin
            n_fail++; $display("FAIL rd_head0 got %h/%b want 1234/11", ftdi_data, ftdi_be);
        end
        rd_n = 1'b0;
        tick();
        n_cmp++; if (ftdi_data !== 16'hABCD || ftdi_be !== 2'b01 || rx_count !== 5'd1) begin
            n_fail++; $display("FAIL rd_head1 got %h/%b cnt %0d want ABCD/01 cnt 1", ftdi_data, ftdi_be, rx_count);
        end
        tick();
        rd_n = 1'b1;
        #1;
        n_cmp++; if (rx_count !== 5'd0 || rxf_n !== 1'b1) begin
            n_fail++; $display("FAIL rd_drained got cnt %0d rxf_n %b want 0/1", rx_count, rxf_n);
        end
        n_cmp++; if (ftdi_data !== 16'h0000 || ftdi_be !== 2'b00) begin
            n_fail++; $display("FAIL rd_empty_bus got %h/%b want 0000/00", ftdi_data, ftdi_be);
        end
        n_cmp++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL rd_bus_err got %b want 0", bus_err); end
        oe_n = 1'b1;
    endtask

    task automatic test_write_full;
        do_reset();
        wr_n = 1'b0; tb_drv = 1'b1; tb_be = 2'b11;
        for (int i = 1; i <= 16; i++) begin
            tb_data = 16'(i);
            tick();
        end
        n_cmp++; if (tx_count !== 5'd16 || txe_n !== 1'b1 || bus_err !== 1'b0) begin
            n_fail++; $display("FAIL wr_full got cnt %0d txe_n %b err %b want 16/1/0", tx_count, txe_n, bus_err);
        end
        tb_data = 16'h0011;
        tick();
        n_cmp++; if (bus_err !== 1'b1 || tx_count !== 5'd16) begin
            n_fail++; $display("FAIL wr_overflow got err %b cnt %0d want 1/16", bus_err, tx_count);
        end
        wr_n = 1'b1; tb_drv = 1'b0;
        tx_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            n_cmp++; if (tx_valid !== 1'b1 || tx_data !== 16'(i) || tx_be !== 2'b11) begin
                n_fail++; $display("FAIL wr_drain%0d got v %b %h/%b want 1 %h/11", i, tx_valid, tx_data, tx_be, 16'(i));
            end
            tick();
        end
        tx_ready = 1'b0;
        n_cmp++; if (tx_valid !== 1'b0 || tx_count !== 5'd0 || txe_n !== 1'b0) begin
            n_fail++; $display("FAIL wr_empty got v %b cnt %0d txe_n %b want 0/0/0", tx_valid, tx_count, txe_n);
        end
    endtask

    task automatic test_be_zero;
        do_reset();
        wr_n = 1'b0; tb_drv = 1'b1; tb_data = 16'hDEAD; tb_be = 2'b00;
        tick(); tick(); tick();
        wr_n = 1'b1; tb_drv = 1'b0;
        n_cmp++; if (tx_count !== 5'd0 || bus_err !== 1'b0 || tx_valid !== 1'b0) begin
            n_fail++; $display("FAIL be0 got cnt %0d err %b v %b want 0/0/0", tx_count, bus_err, tx_valid);
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        for (int i = 0; i < 5; i++) host_push(16'h0100 + 16'(i), 2'b11);
        n_cmp++; if (rx_count !== 5'd5) begin n_fail++; $display("FAIL b2b_fill got %0d want 5", rx_count); end
        oe_n = 1'b0; rd_n = 1'b0; rx_valid = 1'b1; rx_be = 2'b10;
        for (int k = 0; k < 4; k++) begin
            rx_data = 16'h0105 + 16'(k);
            #1;
            n_cmp++; if (ftdi_data !== 16'h0100 + 16'(k)) begin
                n_fail++; $display("FAIL b2b_head%0d got %h want %h", k, ftdi_data, 16'h0100 + 16'(k));
            end
            tick();
            n_cmp++; if (rx_count !== 5'd5) begin n_fail++; $display("FAIL b2b_cnt%0d got %0d want 5", k, rx_count); end
        end
        rx_valid = 1'b0;
        for (int k = 4; k < 9; k++) begin
            #1;
            n_cmp++; if (ftdi_data !== 16'h0100 + 16'(k)) begin
                n_fail++; $display("FAIL b2b_tail%0d got %h want %h", k, ftdi_data, 16'h0100 + 16'(k));
            end
            tick();
        end
        rd_n = 1'b1; oe_n = 1'b1;
        #1;
        n_cmp++; if (rx_count !== 5'd0 || bus_err !== 1'b0) begin
            n_fail++; $display("FAIL b2b_end got cnt %0d err %b want 0/0", rx_count, bus_err);
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        for (int i = 0; i < 8; i++) host_push(16'h0200 + 16'(i), 2'b11);
        n_cmp++; if (rx_count !== 5'd8) begin n_fail++; $display("FAIL rm_fill got %0d want 8", rx_count); end
        oe_n = 1'b0; rd_n = 1'b0;
        tick();
        n_cmp++; if (ftdi_data !== 16'h0201) begin n_fail++; $display("FAIL rm_head got %h want 0201", ftdi_data); end
        rst = 1'b1; tb_drv = 1'b1; tb_data = 16'h0C3C; tb_be = 2'b10;
        #1;
        n_cmp++; if (ftdi_data !== 16'h0C3C || ftdi_be !== 2'b10) begin
            n_fail++; $display("FAIL rm_release got %h/%b want 0C3C/10", ftdi_data, ftdi_be);
        end
        n_cmp++; if (rxf_n !== 1'b1 || rx_count !== 5'd0 || tx_count !== 5'd0) begin
            n_fail++; $display("FAIL rm_flush got rxf_n %b cnt %0d/%0d want 1 0/0", rxf_n, rx_count, tx_count);
        end
        idle();
        tick();
        rst = 1'b0;
        tick();
        n_cmp++; if (txe_n !== 1'b0 || rxf_n !== 1'b1 || bus_err !== 1'b0 || rx_ready !== 1'b1) begin
            n_fail++; $display("FAIL rm_after got txe_n %b rxf_n %b err %b rdy %b want 0/1/0/1",
                               txe_n, rxf_n, bus_err, rx_ready);
        end
    endtask

`ifdef FT600_EMU_TXE_GAP_EN
    task automatic test_txe_gap;
        logic exp_txe [13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
                               1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        int sent = 0;
        do_reset();
        tb_be = 2'b11;
        for (int c = 0; c < 13; c++) begin
            n_cmp++; if (txe_n !== exp_txe[c]) begin
                n_fail++; $display("FAIL gap_c%0d got txe_n %b want %b", c, txe_n, exp_txe[c]);
            end
            if (txe_n == 1'b0 && sent < 8) begin
                sent++;
                wr_n = 1'b0; tb_drv = 1'b1; tb_data = 16'(sent);
            end else begin
                wr_n = 1'b1; tb_drv = 1'b0;
            end
            tick();
        end
        wr_n = 1'b1; tb_drv = 1'b0;
        n_cmp++; if (tx_count !== 5'd8 || bus_err !== 1'b0) begin
            n_fail++; $display("FAIL gap_end got cnt %0d err %b want 8/0", tx_count, bus_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        test_write_full();
        test_be_zero();
        test_back_to_back();
        test_reset_mid();
`ifdef FT600_EMU_TXE_GAP_EN
        test_txe_gap();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ft600_bus_emulator.md
Name: ft600_bus_emulator

Overview:
- Synthesizable emulator of the FT600 chip side of the 245-sync FIFO bus.
- Responds to our FPGA-side FT600 master. It drives RXF_N and TXE_N, sources read data when OE_N/RD_N are low, and captures write data when WR_N is low.
- A simple valid/ready host port loads host-to-FPGA words and drains FPGA-to-host words.
- Used for on-chip loopback and for simulation without FT600 silicon.

Parameters:
- RX_DEPTH, 16: host-to-FPGA FIFO depth in words; power of 2, minimum 4.
- TX_DEPTH, 16: FPGA-to-host FIFO depth in words; power of 2, minimum 4.
- TX_BURST, 8: words per TX packet; used only with FT600_EMU_TXE_GAP_EN.

Ports:
- ftdi_clk  in  1: single clock, all logic on posedge.
- rst  in  1: asynchronous, active-high reset.
- ftdi_rxf_n  out  1: low = RX FIFO holds data.
- ftdi_txe_n  out  1: low = TX FIFO has space.
- ftdi_oe_n  in  1: master output enable; low = emulator drives the bus.
- ftdi_rd_n  in  1: master read strobe.
- ftdi_wr_n  in  1: master write strobe.
- ftdi_data  inout  16: shared data bus.
- ftdi_be  inout  2: shared byte enables.
- host_rx_valid  in  1; host_rx_data  in  16; host_rx_be  in  2; host_rx_ready  out  1: push into RX FIFO.
- host_tx_valid  out  1; host_tx_data  out  16; host_tx_be  out  2; host_tx_ready  in  1: pop from TX FIFO.
- rx_count  out  $clog2(RX_DEPTH)+1; tx_count  out  $clog2(TX_DEPTH)+1: FIFO occupancy.
- bus_err  out  1: sticky protocol-violation flag.

Behaviour:
- Interface as decided: one clock ftdi_clk; reset rst is asynchronous, active-high.
- Reset values:
  - ftdi_rxf_n=1, ftdi_txe_n=1, bus_err=0.
  - FIFOs flushed, both counts 0, host_rx_ready=0, host_tx_valid=0.
  - Tristates released while rst=1.
- After reset release:
  - host_rx_ready=1 at the first posedge.
  - ftdi_txe_n=0 at the first posedge.
- Tristate:
  - Drive enable = ~rst & ~ftdi_oe_n & ftdi_wr_n.
  - Driven value is the RX FIFO head, first-word-fall-through (data, be).
  - When the RX FIFO is empty, drive data=16'h0000, be=2'b00.
- Flags are registered from next-state counts, updated each posedge:
  - ftdi_rxf_n = (rx_count_next==0).
  - ftdi_txe_n = (tx_count_next==TX_DEPTH).
- Read pop: at posedge with oe_n=0, rd_n=0 and RX non-empty.
  - Head retires; the next head is visible after the edge.
  - This gives one word per clock while rd_n stays low.
- Write capture: at posedge with wr_n=0, ftdi_txe_n=0 and ftdi_be!=2'b00.
  - Push {ftdi_data, ftdi_be} into the TX FIFO.
  - be=2'b00 with wr_n=0 is ignored silently; this is the end-of-burst idle word.
- Host RX push: host_rx_valid & host_rx_ready, where host_rx_ready = RX not full.
- Host TX pop: host_tx_valid & host_tx_ready, where host_tx_valid = TX not empty; FWFT.
- Simultaneous push and pop on the same FIFO:
  - Both take effect and the count is unchanged.
  - Push into a full FIFO is impossible because ready=0.
  - When the FIFO is empty, a pop in the same cycle as a push is not performed.
- bus_err is set, and held until rst, on any of:
  - rd_n=0 while RX is empty;
  - wr_n=0 with be!=00 while ftdi_txe_n=1 (the word is dropped);
  - oe_n=0 and wr_n=0 in the same cycle (contention; the emulator does not drive).
- Reset mid-burst: in-flight words are discarded and the bus is released asynchronously.
- Counts wrap-free: pointers are $clog2(DEPTH) bits with an extra count bit.

Optional Feature:
- Macro FT600_EMU_TXE_GAP_EN.
- Defined:
  - Count accepted TX words.
  - After every TX_BURST words, force ftdi_txe_n=1 for exactly 2 cycles, regardless of space; this models FT600 packet boundaries.
  - The counter resets on rst.
  - A write during the gap counts as a bus_err violation.
- Undefined: ftdi_txe_n depends on FIFO space only.

Decomposition:
- Package ft600_pkg:
  - localparam FT_DATA_W=16, FT_BE_W=2.
  - typedef struct packed {logic [15:0] data; logic [1:0] be;} ft600_word_t.
- Sub-module ft600_emu_fifo: FWFT synchronous FIFO of ft600_word_t.
  - Parameter DEPTH.
  - Ports: push/pop, full/empty, count.
  - Instantiated twice (RX, TX).

Test Plan:
1. Reset, then push host_rx 0x1234/be=11 and 0xABCD/be=01 -> rxf_n falls 1 clk after the first push. Master OE, then RD low for 2 clks -> bus shows 0x1234 then 0xABCD, rx_count 2→0, rxf_n=1 after the final pop, bus_err=0.
2. Master writes 0x0001..0x0010 (16 words, be=11) with host_tx_ready=0 -> txe_n=1 after the 16th; a 17th write attempt sets bus_err and is dropped. Then host_tx_ready=1 -> words pop out in order 0x0001..0x0010.
3. wr_n=0 with be=00 for 3 clks -> tx_count stays 0, bus_err=0.
4. Simultaneous host_rx push and bus pop with rx_count=5 for 4 clks -> rx_count stays 5, data order preserved.
5. Assert rst mid-read-burst (rx_count=8) -> bus Z immediately, rxf_n=1, counts 0; after release, txe_n=0 at the next posedge.
6. With FT600_EMU_TXE_GAP_EN, TX_BURST=4, write 8 words back-to-back -> txe_n high for exactly 2 clks after words 4 and 8, no bus_err.
